// File: rtl/gate_arbiter.sv
// rtl/gate_arbiter.sv - round-robin scheduler sharing the parking FSM among two entry and two exit gates
// One transaction at a time: IDLE picks a gate, ISSUE sends the command, WAIT_ACK waits for doorOpen, HOLD drives the barrier.
module gate_arbiter #(
  parameter int DOOR_CYCLES = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] entReq,
  input  logic [1:0] extReq,
  input  logic [1:0] extLoc0,
  input  logic [1:0] extLoc1,
  input  logic       isFull,
  input  logic       doorOpen,
  output logic       enter,
  output logic       exit,
  output logic [1:0] exitLocation,
  output logic [1:0] entGrant,
  output logic [1:0] extGrant,
  output logic [3:0] gateOpen,
  output logic       fullWait,
  output logic       ackErr,
  output logic [1:0] state
);
  localparam int CMAX = (DOOR_CYCLES > ACK_TIMEOUT) ? DOOR_CYCLES : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DOOR_LD  = CW'(DOOR_CYCLES);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t        r_state;
  logic [1:0]    r_rr_ptr;
  logic [1:0]    r_sel;
  logic [1:0]    r_loc;
  logic [CW-1:0] r_cnt;
  logic          r_enter;
  logic          r_exit;
  logic [1:0]    r_exit_loc;
  logic [1:0]    r_ent_grant;
  logic [1:0]    r_ext_grant;
  logic [3:0]    r_gate_open;
  logic          r_ack_err;

  logic [3:0] w_elig;
  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic [3:0] w_sel_onehot;

  // Entries are masked while the lot is full; exits are always eligible.
  assign w_elig       = {extReq, entReq & ~{2{isFull}}};
  assign w_sel_onehot = 4'b0001 << r_sel;

  // Scanning from the farthest offset down leaves the nearest eligible index at or after the pointer.
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = r_rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_rr_ptr + 2'(i);
      if (w_elig[w_idx]) w_pick = w_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 2'd0;
      r_sel       <= 2'd0;
      r_loc       <= 2'd0;
      r_cnt       <= '0;
      r_enter     <= 1'b0;
      r_exit      <= 1'b0;
      r_exit_loc  <= 2'd0;
      r_ent_grant <= 2'd0;
      r_ext_grant <= 2'd0;
      r_gate_open <= 4'd0;
      r_ack_err   <= 1'b0;
    end else begin
      r_enter     <= 1'b0;
      r_exit      <= 1'b0;
      r_exit_loc  <= 2'd0;
      r_ent_grant <= 2'd0;
      r_ext_grant <= 2'd0;
      r_gate_open <= 4'd0;
      r_ack_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_sel   <= w_pick;
            r_loc   <= w_pick[0] ? extLoc1 : extLoc0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_enter    <= ~r_sel[1];
          r_exit     <= r_sel[1];
          r_exit_loc <= r_sel[1] ? r_loc : 2'd0;
          r_cnt      <= '0;
          r_state    <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (doorOpen) begin
            r_cnt    <= DOOR_LD;
            r_rr_ptr <= r_sel + 2'd1;
            r_state  <= HOLD;
          end else if (r_cnt == ACK_LAST) begin
            r_ack_err <= 1'b1;
            r_rr_ptr  <= r_sel + 2'd1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + ONE;
          end
        end
        HOLD: begin
          r_gate_open <= w_sel_onehot;
          // The counter still holds its load value only on the first hold cycle.
          if (r_cnt == DOOR_LD) begin
            r_ent_grant <= w_sel_onehot[1:0];
            r_ext_grant <= w_sel_onehot[3:2];
          end
          if (r_cnt == ONE) r_state <= IDLE;
          else r_cnt <= r_cnt - ONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign enter        = r_enter;
  assign exit         = r_exit;
  assign exitLocation = r_exit_loc;
  assign entGrant     = r_ent_grant;
  assign extGrant     = r_ext_grant;
  assign gateOpen     = r_gate_open;
  assign ackErr       = r_ack_err;
  assign state        = r_state;
  assign fullWait     = isFull & (|entReq);

endmodule

// File: doc/gate_arbiter.md
# gate_arbiter

Round-robin scheduler that shares the single parking FSM among two entry gates and two exit gates. It picks one pending gate request, drives a one-cycle `enter` or `exit` command (with `exitLocation`) into the FSM, and waits for the FSM's `doorOpen` acknowledge. It then holds that gate's barrier open for a fixed time before serving the next gate. It sits between the gate sensors and the FSM inputs `enter`, `exit` and `exitLocation`.

## Interface

Parameters:
- `DOOR_CYCLES`, default 4: number of cycles a barrier stays open after acknowledge (≥1).
- `ACK_TIMEOUT`, default 8: maximum cycles spent waiting for `doorOpen` (≥1).

Ports:
- `clk`, input, 1: the single clock; rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `entReq`, input, 2: entry-gate requests, level-held; bit g = entry gate g.
- `extReq`, input, 2: exit-gate requests, level-held.
- `extLoc0`, input, 2: slot being vacated via exit gate 0.
- `extLoc1`, input, 2: slot being vacated via exit gate 1.
- `isFull`, input, 1: from the FSM; lot full.
- `doorOpen`, input, 1: from the FSM; acknowledges the command.
- `enter`, output, 1: command pulse to the FSM.
- `exit`, output, 1: command pulse to the FSM.
- `exitLocation`, output, 2: slot sent with `exit`; 0 otherwise.
- `entGrant`, output, 2: one-cycle pulse on acknowledge of an entry gate.
- `extGrant`, output, 2: one-cycle pulse on acknowledge of an exit gate.
- `gateOpen`, output, 4: barrier drive, indexed {ext1, ext0, ent1, ent0}.
- `fullWait`, output, 1: high while any entry request is blocked by `isFull`.
- `ackErr`, output, 1: one-cycle pulse on acknowledge timeout.
- `state`, output, 2: current state encoding.

## Operation

- Requester indices: 0 = ent0, 1 = ent1, 2 = ext0, 3 = ext1.
- Eligible requesters are `{extReq, entReq & ~{2{isFull}}}`.
- States:
  - IDLE = 0
  - ISSUE = 1
  - WAIT_ACK = 2
  - HOLD = 3
- IDLE:
  - If any requester is eligible, choose the first eligible index at or after `rrPtr` (modulo 4).
  - Latch the chosen index `sel`.
  - For an exit, also latch the location: `extLoc0` for index 2, `extLoc1` for index 3.
  - Go to ISSUE.
- ISSUE, one cycle only:
  - Drive `enter`=1 if `sel`<2; otherwise drive `exit`=1 with `exitLocation`=the latched location.
  - Clear the wait counter and go to WAIT_ACK.
- WAIT_ACK:
  - `enter`, `exit` and `exitLocation` are all 0.
  - If `doorOpen`=1: pulse the grant bit for `sel`, load the hold counter with `DOOR_CYCLES`, and go to HOLD.
  - Otherwise, when the counter reaches `ACK_TIMEOUT`: pulse `ackErr` and go to IDLE (no grant, no barrier).
- HOLD:
  - `gateOpen[sel]`=1.
  - Decrement the counter each cycle; at 1, go to IDLE.
  - Barrier is high for exactly `DOOR_CYCLES` cycles.
- `rrPtr` advances to `sel`+1 (mod 4) on leaving WAIT_ACK, whether by grant or by timeout.
- Once the command is issued, the transaction is committed. Request deassertion during WAIT_ACK or HOLD has no effect.
- A request that is still held after its own grant is served again only when round-robin reaches it again.
- `isFull` rising after an entry has been issued does not cancel that entry.
- `fullWait` = `isFull & |entReq`, combinational and independent of state.
- Location widths are fixed at 2 bits; `rrPtr` and `sel` are 2 bits and wrap naturally.

## Timing

- All outputs except `fullWait` are registered.
- Reset (asserted low, takes effect immediately):
  - `state`=IDLE.
  - `rrPtr`=0.
  - Counters cleared.
  - `enter`=`exit`=0, `exitLocation`=0, `entGrant`=`extGrant`=0, `gateOpen`=0, `ackErr`=0.
- Reset mid-transaction aborts it: no grant, barrier closes immediately.
- Request sampled at edge k (state IDLE) → command visible from edge k+1 for one cycle.
- With `doorOpen` already high, the grant pulse and first `gateOpen` cycle start at edge k+3.
- Minimum service period per request: 3 + `DOOR_CYCLES` cycles. No back-to-back commands; IDLE always separates transactions.
- Timeout: `ackErr` pulses `ACK_TIMEOUT` cycles after WAIT_ACK entry, and `state` returns to IDLE on the same edge.
- Simultaneous requests are served one per transaction in round-robin order. No requester waits more than 3 other transactions.

## Test plan

1. Reset low mid-HOLD, then release → all outputs 0 and `state`=0 immediately; the next request is selected starting from index 0.
2. `entReq`=01, `isFull`=0, `doorOpen` tied 1 → `enter` high for exactly 1 cycle; `entGrant`=01 pulses 3 cycles after the request edge; `gateOpen`=0001 for 4 cycles; then IDLE.
3. `extReq`=10, `extLoc1`=2'b11 → `exit`=1 with `exitLocation`=11 for one cycle; `extGrant`=10 pulses; `gateOpen`=1000.
4. All four requests held, `doorOpen`=1 → grant order ent0, ent1, ext0, ext1, ent0, … with a 7-cycle spacing.
5. `isFull`=1, `entReq`=11, `extReq`=00 → `fullWait`=1 and no command issued. Raise `extReq`=01 → exit served; drop `isFull` → entries are served in round-robin order.
6. `doorOpen` held 0 after ISSUE → `ackErr` pulses after 8 WAIT_ACK cycles with no grant; the next requester in round-robin order is served afterwards.
